// File: rtl/ntt_ct_butterfly_if.sv
// ntt_ct_butterfly_if
//   Streaming bus for one Cooley-Tukey butterfly unit.
//   Input side : in_valid, in_a, in_b, in_w (30-bit residues), in_tag.
//   Output side: out_valid, out_x = (a + b*w) mod q, out_y = (a - b*w) mod q, out_tag.
//   master : producer of butterflies / consumer of results (RAM read + write-back side).
//   slave  : the butterfly pipeline itself.
interface ntt_ct_butterfly_if #(
   parameter int TAG_W = 10
);
   logic             in_valid;
   logic [29:0]      in_a;
   logic [29:0]      in_b;
   logic [29:0]      in_w;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic [29:0]      out_x;
   logic [29:0]      out_y;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_b, in_w, in_tag,
      input  out_valid, out_x, out_y, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_w, in_tag,
      output out_valid, out_x, out_y, out_tag
   );
endinterface

// File: rtl/ntt_ct_butterfly.sv
// ntt_ct_butterfly
//   Fully pipelined Cooley-Tukey NTT butterfly, 6-cycle latency, one butterfly
//   per cycle, no backpressure.
//   Ports:
//     clk   - single clock, all state on the rising edge
//     rst_n - synchronous active-low reset (clears valid chain and outputs)
//     bus   - ntt_ct_butterfly_if.slave: in_valid/in_a/in_b/in_w/in_tag in,
//             out_valid/out_x/out_y/out_tag out
//   Also contains windowed_reduction60bit, the 3-cycle p mod q reducer used
//   by the butterfly.

// windowed_reduction60bit
//   t = p mod q for any 60-bit p, 3-cycle latency, no reset.
//   Ports: clk in, p in 60 (sampled combinationally at the first edge), t out 30 (registered).
//   Barrett reduction with mu = floor(2^60 / q); since 2^29 <= q < 2^30 the
//   quotient estimate is at most 2 below the true quotient, so the partial
//   remainder lies in [0, 3q) and two conditional subtractions finish it.
module windowed_reduction60bit #(
   parameter int MOD_INDEX = 0
) (
   input  logic        clk,
   input  logic [59:0] p,
   output logic [29:0] t
);
   function automatic logic [29:0] modulus(input int idx);
      logic [29:0] q;
      case (idx)
         0:       q = 30'd1063321601;
         1:       q = 30'd1063452673;
         2:       q = 30'd1064697857;
         3:       q = 30'd1065484289;
         4:       q = 30'd1065811969;
         5:       q = 30'd1068236801;
         6:       q = 30'd1068433409;
         7:       q = 30'd1068564481;
         8:       q = 30'd1069219841;
         9:       q = 30'd1070727169;
         10:      q = 30'd1071513601;
         11:      q = 30'd1072496641;
         12:      q = 30'd1073479681;
         default: q = 30'd1063321601;
      endcase
      return q;
   endfunction

   localparam logic [29:0] Q  = modulus(MOD_INDEX);
   localparam logic [30:0] MU = 31'((64'd1 << 60) / {34'd0, Q});
   localparam logic [31:0] Q1 = {2'b00, Q};
   localparam logic [31:0] Q2 = {1'b0, Q, 1'b0};

   logic [30:0] qhat_r;
   logic [31:0] p_lo_r;
   logic [31:0] r_r;
   logic [29:0] t_s;

   // Quotient estimate floor(floor(p / 2^29) * mu / 2^31); low p bits kept for the remainder.
   always_ff @(posedge clk) begin
      qhat_r <= 31'(({31'd0, p[59:29]} * {31'd0, MU}) >> 31);
      p_lo_r <= p[31:0];
   end

   // Partial remainder is < 3q < 2^32, so modulo-2^32 arithmetic gives it exactly.
   always_ff @(posedge clk) begin
      r_r <= p_lo_r - ({1'b0, qhat_r} * Q1);
   end

   // Final correction from [0, 3q) into [0, q).
   always_comb begin
      t_s = r_r[29:0];
      if (r_r >= Q2) begin
         t_s = 30'(r_r - Q2);
      end else if (r_r >= Q1) begin
         t_s = 30'(r_r - Q1);
      end else begin
         t_s = r_r[29:0];
      end
   end

   // Registered reduction output.
   always_ff @(posedge clk) begin
      t <= t_s;
   end
endmodule

module ntt_ct_butterfly #(
   parameter int MOD_INDEX = 0,
   parameter int TAG_W     = 10
) (
   input logic                clk,
   input logic                rst_n,
   ntt_ct_butterfly_if.slave  bus
);
   function automatic logic [29:0] modulus(input int idx);
      logic [29:0] q;
      case (idx)
         0:       q = 30'd1063321601;
         1:       q = 30'd1063452673;
         2:       q = 30'd1064697857;
         3:       q = 30'd1065484289;
         4:       q = 30'd1065811969;
         5:       q = 30'd1068236801;
         6:       q = 30'd1068433409;
         7:       q = 30'd1068564481;
         8:       q = 30'd1069219841;
         9:       q = 30'd1070727169;
         10:      q = 30'd1071513601;
         11:      q = 30'd1072496641;
         12:      q = 30'd1073479681;
         default: q = 30'd1063321601;
      endcase
      return q;
   endfunction

   localparam logic [29:0] Q  = modulus(MOD_INDEX);
   localparam logic [30:0] QE = {1'b0, Q};

   // vld_r[0]=S1, [1]=S2, [4:2]=reduction-matched delay; out_valid is the sixth stage.
   logic [4:0]       vld_r;
   logic [29:0]      a1_r;
   logic [29:0]      b1_r;
   logic [29:0]      w1_r;
   logic [TAG_W-1:0] tag1_r;
   logic [59:0]      p2_r;
   logic [29:0]      a2_r;
   logic [TAG_W-1:0] tag2_r;
   logic [29:0]      a_dly_r   [0:2];
   logic [TAG_W-1:0] tag_dly_r [0:2];
   logic [29:0]      t_s;
   logic [30:0]      sum_s;
   logic [30:0]      dif_s;
   logic [29:0]      x_s;
   logic [29:0]      y_s;

   // Valid chain; the only pipeline state that needs reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_r <= 5'b0_0000;
      end else begin
         vld_r <= {vld_r[3:0], bus.in_valid};
      end
   end

   // Data path registers: S1 capture, S2 product, delay line matched to the reducer.
   always_ff @(posedge clk) begin
      a1_r         <= bus.in_a;
      b1_r         <= bus.in_b;
      w1_r         <= bus.in_w;
      tag1_r       <= bus.in_tag;
      p2_r         <= {30'd0, b1_r} * {30'd0, w1_r};
      a2_r         <= a1_r;
      tag2_r       <= tag1_r;
      a_dly_r[0]   <= a2_r;
      a_dly_r[1]   <= a_dly_r[0];
      a_dly_r[2]   <= a_dly_r[1];
      tag_dly_r[0] <= tag2_r;
      tag_dly_r[1] <= tag_dly_r[0];
      tag_dly_r[2] <= tag_dly_r[1];
   end

   windowed_reduction60bit #(
      .MOD_INDEX (MOD_INDEX)
   ) u_red (
      .clk (clk),
      .p   (p2_r),
      .t   (t_s)
   );

   // Modular add/sub; d is read as signed through its top bit since |a - t| < 2^30.
   always_comb begin
      sum_s = {1'b0, a_dly_r[2]} + {1'b0, t_s};
      dif_s = {1'b0, a_dly_r[2]} - {1'b0, t_s};
      x_s   = sum_s[29:0];
      y_s   = dif_s[29:0];
      if (sum_s >= QE) begin
         x_s = 30'(sum_s - QE);
      end else begin
         x_s = sum_s[29:0];
      end
      if (dif_s[30]) begin
         y_s = 30'(dif_s + QE);
      end else begin
         y_s = dif_s[29:0];
      end
   end

   // Output stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_x     <= 30'd0;
         bus.out_y     <= 30'd0;
         bus.out_tag   <= '0;
      end else begin
         bus.out_valid <= vld_r[4];
         bus.out_x     <= x_s;
         bus.out_y     <= y_s;
         bus.out_tag   <= tag_dly_r[2];
      end
   end
endmodule

// File: tb/tb_ntt_ct_butterfly.sv
// tb_ntt_ct_butterfly
//   Scoreboard bench for ntt_ct_butterfly. Two instances: MOD_INDEX=0 (bus0)
//   and MOD_INDEX=12 (bus1). The driver pushes expected results (with the
//   cycle they are due) into per-instance queues; a negedge monitor pops and
//   compares whenever out_valid is high.
module tb_ntt_ct_butterfly;
   localparam int          TAG_W = 10;
   localparam logic [29:0] Q0    = 30'd1063321601;
   localparam logic [29:0] Q12   = 30'd1073479681;

   typedef struct {
      logic [29:0]      x;
      logic [29:0]      y;
      logic [TAG_W-1:0] tag;
      int               due;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks   = 0;
   int   failures = 0;
   int   pushed0 = 0, pushed1 = 0, flushed0 = 0, flushed1 = 0, seen0 = 0, seen1 = 0;
   exp_t exp0_q[$];
   exp_t exp1_q[$];

   ntt_ct_butterfly_if #(.TAG_W(TAG_W)) bus0 ();
   ntt_ct_butterfly_if #(.TAG_W(TAG_W)) bus1 ();

   ntt_ct_butterfly #(.MOD_INDEX(0), .TAG_W(TAG_W)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   ntt_ct_butterfly #(.MOD_INDEX(12), .TAG_W(TAG_W)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [29:0] a, b, w, input logic [TAG_W-1:0] tag);
      bus0.in_valid = v; bus0.in_a = a; bus0.in_b = b; bus0.in_w = w; bus0.in_tag = tag;
   endtask

   task automatic drive1(input logic v, input logic [29:0] a, b, w, input logic [TAG_W-1:0] tag);
      bus1.in_valid = v; bus1.in_a = a; bus1.in_b = b; bus1.in_w = w; bus1.in_tag = tag;
   endtask

   // Expected result is due 6 cycles after the cycle in which it is driven.
   task automatic push(input int inst, input logic [29:0] x, y, input logic [TAG_W-1:0] tag);
      exp_t e;
      e.x = x; e.y = y; e.tag = tag; e.due = cyc + 6;
      if (inst == 0) begin exp0_q.push_back(e); pushed0++; end
      else begin exp1_q.push_back(e); pushed1++; end
   endtask

   // Independent reference: plain 64-bit modular arithmetic.
   task automatic push_model(input logic [29:0] a, b, w, input logic [TAG_W-1:0] tag);
      logic [63:0] t, x, y;
      t = ({34'd0, b} * {34'd0, w}) % {34'd0, Q0};
      x = ({34'd0, a} + t) % {34'd0, Q0};
      y = ({34'd0, a} + {34'd0, Q0} - t) % {34'd0, Q0};
      push(0, x[29:0], y[29:0], tag);
   endtask

   task automatic mon(input int inst, input logic [29:0] x, y, input logic [TAG_W-1:0] tag);
      exp_t e;
      int   n;
      n = (inst == 0) ? exp0_q.size() : exp1_q.size();
      if (n == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_out: inst%0d out_valid=1 tag=%0d at cycle %0d, required no output", inst, tag, cyc);
      end else begin
         if (inst == 0) begin e = exp0_q.pop_front(); seen0++; end
         else begin e = exp1_q.pop_front(); seen1++; end
         check($sformatf("x inst%0d tag%0d", inst, e.tag), 64'(x), 64'(e.x));
         check($sformatf("y inst%0d tag%0d", inst, e.tag), 64'(y), 64'(e.y));
         check($sformatf("tag inst%0d", inst), 64'(tag), 64'(e.tag));
         check($sformatf("latency_cycle inst%0d tag%0d", inst, e.tag), 64'(cyc), 64'(e.due));
      end
   endtask

   // Monitor: compares every presented result against the scoreboard.
   always @(negedge clk) begin
      if (bus0.out_valid === 1'b1) mon(0, bus0.out_x, bus0.out_y, bus0.out_tag);
      if (bus1.out_valid === 1'b1) mon(1, bus1.out_x, bus1.out_y, bus1.out_tag);
   end

   task automatic check_reset_outputs(input string name);
      check({name, " out_valid0"}, 64'(bus0.out_valid), 64'd0);
      check({name, " out_x0"},     64'(bus0.out_x),     64'd0);
      check({name, " out_y0"},     64'(bus0.out_y),     64'd0);
      check({name, " out_tag0"},   64'(bus0.out_tag),   64'd0);
      check({name, " out_valid1"}, 64'(bus1.out_valid), 64'd0);
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < limit) begin
         tick();
         n++;
      end
      if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d results pending, required 0", exp0_q.size() + exp1_q.size());
      end
      repeat (3) tick();
   endtask

   initial begin
      logic [29:0] ra, rb, rw;
      bit   [6:0]  pat;
      drive0(1'b0, 30'd0, 30'd0, 30'd0, '0);
      drive1(1'b0, 30'd0, 30'd0, 30'd0, '0);

      // Reset with valid inputs presented: they must be ignored.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive0(1'b1, 30'd11, 30'd22, 30'd33, TAG_W'(i + 900));
         tick();
         check_reset_outputs("reset");
      end
      rst_n = 1'b1;
      drive0(1'b0, 30'd0, 30'd0, 30'd0, '0);
      tick();

      // Directed vectors, hand-computed results (q0 = 1063321601, q12 = 1073479681).
      drive0(1'b1, 30'd5, 30'd3, 30'd7, 10'd1);                      push(0, 30'd26, 30'd1063321585, 10'd1); tick();
      drive0(1'b1, 30'd1063321600, 30'd1, 30'd1, 10'd2);             push(0, 30'd0, 30'd1063321599, 10'd2); tick();
      drive0(1'b1, 30'd0, 30'd1063321600, 30'd1063321600, 10'd3);    push(0, 30'd1, 30'd1063321600, 10'd3); tick();
      drive0(1'b1, 30'd1063321600, 30'd1063321600, 30'd1063321600, 10'd4);
      push(0, 30'd0, 30'd1063321599, 10'd4);
      drive1(1'b1, 30'd1073479680, 30'd1073479680, 30'd1073479680, 10'd5);
      push(1, 30'd0, 30'd1073479679, 10'd5);
      tick();
      drive1(1'b0, 30'd0, 30'd0, 30'd0, '0);
      drive0(1'b1, 30'd100, 30'd0, 30'd5, 10'd6);                    push(0, 30'd100, 30'd100, 10'd6); tick();
      drive0(1'b1, 30'd1063321600, 30'd2, 30'd3, 10'd7);             push(0, 30'd5, 30'd1063321594, 10'd7); tick();
      drive0(1'b0, 30'd0, 30'd0, 30'd0, '0);
      drain(30);

      // Streaming: 64 back-to-back random butterflies, tags 0..63.
      for (int i = 0; i < 64; i++) begin
         ra = 30'($urandom % 32'(Q0));
         rb = 30'($urandom % 32'(Q0));
         rw = 30'($urandom % 32'(Q0));
         drive0(1'b1, ra, rb, rw, TAG_W'(i));
         push_model(ra, rb, rw, TAG_W'(i));
         tick();
      end
      drive0(1'b0, 30'd0, 30'd0, 30'd0, '0);
      drain(30);

      // Bubbles: pattern 1,0,0,1,1,0,1; idle slots carry random data.
      pat = 7'b1011001;
      for (int i = 0; i < 7; i++) begin
         ra = 30'($urandom % 32'(Q0));
         rb = 30'($urandom % 32'(Q0));
         rw = 30'($urandom % 32'(Q0));
         drive0(pat[i], ra, rb, rw, TAG_W'(100 + i));
         if (pat[i]) push_model(ra, rb, rw, TAG_W'(100 + i));
         tick();
      end
      drive0(1'b0, 30'd0, 30'd0, 30'd0, '0);
      drain(30);

      // Reset mid-stream: 4 butterflies, reset during the 4th cycle.
      for (int i = 0; i < 4; i++) begin
         drive0(1'b1, 30'd1000 + 30'(i), 30'd7, 30'd9, TAG_W'(200 + i));
         if (i == 3) begin
            rst_n = 1'b0;
            flushed0 += exp0_q.size();
            flushed1 += exp1_q.size();
            exp0_q.delete();
            exp1_q.delete();
         end else begin
            push_model(30'd1000 + 30'(i), 30'd7, 30'd9, TAG_W'(200 + i));
         end
         tick();
      end
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      // t = 600, x = 610, y = q0 - 590
      drive0(1'b1, 30'd10, 30'd20, 30'd30, 10'd300);
      push(0, 30'd610, 30'd1063321011, 10'd300);
      tick();
      drive0(1'b0, 30'd0, 30'd0, 30'd0, '0);
      drain(30);
      repeat (8) tick();

      check("results_seen inst0", 64'(seen0), 64'(pushed0 - flushed0));
      check("results_seen inst1", 64'(seen1), 64'(pushed1 - flushed1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
